// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor built around one full-adder cell
// and a carry flop. It processes one operand bit per clock, LSB first, and
// publishes the WIDTH-bit result plus carry/borrow with a one-cycle done pulse.
//
// Handshake: a request is accepted on any rising edge where start=1 while the
// block is not busy (IDLE or DONE state). Operands, sub and cin are sampled on
// that edge only. busy is high for exactly WIDTH cycles while bits are being
// processed, and start is ignored during that time. done is high for exactly
// one cycle, and s/cout change only in that cycle. A new start during the done
// cycle is accepted immediately, so operations can run back to back.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  // The single full-adder cell working on the current LSBs.
  logic sum_bit;
  logic maj_bit;
  assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign maj_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // Next-state logic: accept in IDLE/DONE, one bit per clock in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1 - cin, so invert B and seed carry with ~cin.
          a_d     = a;
          b_d     = sub ? ~b : b;
          r_d     = '0;
          cnt_d   = '0;
          carry_d = cin ^ sub;
          sub_d   = sub;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        r_d     = {sum_bit, r_q[WIDTH-1:1]};
        carry_d = maj_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          s_d     = {sum_bit, r_q[WIDTH-1:1]};
          // A carry out of a + ~b + ~cin means no borrow, hence the inversion.
          cout_d  = maj_bit ^ sub_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign s           = s_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random operations on serial_addsub, checked
// against an arithmetic reference model of add/subtract with carry/borrow.
module tb_serial_addsub;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sub         (sub),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .s           (s),
    .cout        (cout),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {cout, s}.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    int va, vb, vc, d;
    logic [W:0] r;
    va = int'(ma);
    vb = int'(mb);
    vc = int'(mc);
    if (!ms) begin
      d = va + vb + vc;
      r = (W + 1)'(d);
    end else begin
      d = va - vb - vc;
      r[W-1:0] = W'(d);
      r[W]     = (d < 0);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation. With b2b=1 the caller is already at the negedge of a
  // done cycle and start is raised there. With poke=1 a second start with
  // random operands is pulsed mid-run. Returns at the negedge of the done cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic ts, input bit b2b, input bit poke, input string tag);
    int cycles, busy_cnt;
    logic [W:0] exp;
    exp = model(ta, tb_v, tc, ts);
    if (!b2b) @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands wander after acceptance; the result must not care.
    a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom()); sub = 1'($urandom());
    cycles = 0;
    busy_cnt = 0;
    while (cycles < 20) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      cycles++;
      if (poke) begin
        start = (cycles == 2);
        a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom()); sub = 1'($urandom());
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cycles), 32'(W));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " s"}, 32'(s), 32'(exp[W-1:0]));
    check({tag, " cout"}, 32'(cout), 32'(exp[W]));
  endtask

  // After a done cycle (not back to back): done drops and results hold.
  task automatic check_tail(input string tag);
    logic [W-1:0] s_hold;
    logic         c_hold;
    s_hold = s;
    c_hold = cout;
    @(negedge clk);
    check({tag, " done_pulse_1cycle"}, 32'(done), 32'd0);
    check({tag, " s_held"}, 32'(s), 32'(s_hold));
    check({tag, " cout_held"}, 32'(cout), 32'(c_hold));
  endtask

  // Stimulus, directed then random
  initial begin
    int done_seen;
    bit b2b;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset s", 32'(s), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, "add_1_1");
    check_tail("add_1_1");
    do_op(4'b1011, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, "add_carry");
    do_op(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, "add_wrap");
    do_op(4'b1001, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, "sub_nb");
    check_tail("sub_nb");
    do_op(4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, "sub_borrow");
    do_op(4'b0111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, "add_cin");
    do_op(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, "sub_bin");

    // Start mid-run is ignored.
    do_op(4'b0110, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, "ignore_midrun");
    check_tail("ignore_midrun");

    // Back-to-back: second op accepted in the done cycle.
    do_op(4'b0101, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_first");
    do_op(4'b1100, 4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, "b2b_second");
    check_tail("b2b_second");

    // Reset during RUN after two bits.
    do_op(4'b1010, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    a = 4'b0110; b = 4'b0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_reset busy", 32'(busy), 32'd0);
    check("midrun_reset done", 32'(done), 32'd0);
    check("midrun_reset s", 32'(s), 32'd0);
    check("midrun_reset cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("midrun_reset no_done", 32'(done_seen), 32'd0);
    do_op(4'b0011, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");

    // Random operations, some back to back.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      b2b = (i > 0) && ($urandom_range(0, 1) == 1);
      do_op(ra, rb, 1'($urandom()), 1'($urandom()), b2b, 1'($urandom_range(0, 3) == 0), "rand");
    end
    check_tail("rand_last");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
